// File: rtl/ahb_interconnect_dfs.sv
// AHB-Lite single-master decoder/response mux with built-in default (ERROR) slave.
// Define AHB_IC_TIMEOUT_EN to add the per-slave stall watchdog with fencing and a sticky fault flag.
module ahb_interconnect_dfs #(
    parameter int unsigned SLAVES  = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                         s_clk_i,
    input  logic                         s_reset_i,
    input  logic [AW-1:0]                s_mhaddr_i,
    input  logic [1:0]                   s_mhtrans_i,
    input  logic [SLAVES-1:0][AW-1:0]    s_sbase_i,
    input  logic [SLAVES-1:0][AW-1:0]    s_smask_i,
    input  logic [SLAVES-1:0][DW-1:0]    s_shrdata_i,
    input  logic [SLAVES-1:0]            s_shready_i,
    input  logic [SLAVES-1:0]            s_shresp_i,
    output logic [SLAVES-1:0]            s_hsel_o,
    output logic                         s_shreadyin_o,
    output logic [DW-1:0]                s_shrdata_o,
    output logic                         s_shready_o,
    output logic                         s_shresp_o,
    output logic [SLAVES-1:0]            s_fence_o,
    output logic                         s_fault_o
);

    localparam int unsigned DselW = $clog2(SLAVES + 1);
    localparam logic [DselW-1:0] DefSel = DselW'(SLAVES);

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} st_e;

    st_e               st_q;
    logic [DselW-1:0]  dsel_q;
    logic              active_q;
    logic [DselW-1:0]  dec;
    logic [SLAVES-1:0] own_oh;
    logic [SLAVES-1:0] fence;
    logic              expire;
    logic              hready;
    logic              hresp;
    logic [DW-1:0]     hrdata;
    logic              unused_trans0;

    // NONSEQ/SEQ are distinguished from IDLE/BUSY by bit 1 alone.
    assign unused_trans0 = s_mhtrans_i[0];

    // Iterate downwards so the lowest matching index is the last assignment.
    always_comb begin
        dec = DefSel;
        for (int i = int'(SLAVES) - 1; i >= 0; i--) begin
            if (((s_mhaddr_i & s_smask_i[i]) == s_sbase_i[i]) && !fence[i]) begin
                dec = DselW'(i);
            end
        end
    end

    always_comb begin
        s_hsel_o = '0;
        own_oh   = '0;
        for (int i = 0; i < int'(SLAVES); i++) begin
            s_hsel_o[i] = (dec == DselW'(i));
            own_oh[i]   = (dsel_q == DselW'(i));
        end
    end

    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        if (dsel_q == DefSel) begin
            hready = (st_q != StErr1);
            hresp  = (st_q != StIdle);
        end else if (active_q) begin
            for (int i = 0; i < int'(SLAVES); i++) begin
                if (own_oh[i]) begin
                    hrdata = s_shrdata_i[i];
                    hready = s_shready_i[i];
                    hresp  = s_shresp_i[i];
                end
            end
        end
    end

    assign s_shrdata_o   = hrdata;
    assign s_shready_o   = hready;
    assign s_shreadyin_o = hready;
    assign s_shresp_o    = hresp;

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            st_q     <= StIdle;
            dsel_q   <= DefSel;
            active_q <= 1'b0;
        end else if (expire) begin
            st_q   <= StErr1;
            dsel_q <= DefSel;
        end else if (hready) begin
            dsel_q   <= dec;
            active_q <= s_mhtrans_i[1];
            st_q     <= (s_mhtrans_i[1] && (dec == DefSel)) ? StErr1 : StIdle;
        end else if (st_q == StErr1) begin
            st_q <= StErr2;
        end
    end

`ifdef AHB_IC_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0]   cnt_q;
    logic [SLAVES-1:0] fence_q;
    logic              fault_q;
    logic              stall;

    assign stall  = active_q && (|(own_oh & ~s_shready_i));
    assign expire = stall && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            cnt_q   <= '0;
            fence_q <= '0;
            fault_q <= 1'b0;
        end else if (expire) begin
            cnt_q   <= '0;
            fence_q <= fence_q | own_oh;
            fault_q <= 1'b1;
        end else if (stall) begin
            cnt_q <= cnt_q + CntW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign fence     = fence_q;
    assign s_fence_o = fence_q;
    assign s_fault_o = fault_q;
`else
    assign expire    = 1'b0;
    assign fence     = '0;
    assign s_fence_o = '0;
    assign s_fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_interconnect_dfs.sv
// Directed bench for ahb_interconnect_dfs: vector table for single transfers plus
// hand-written sequences for error responses, stalls, watchdog and reset.
module tb_ahb_interconnect_dfs;

    localparam int unsigned SLAVES = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [31:0]              haddr;
    logic [1:0]               htrans;
    logic [SLAVES-1:0][31:0]  sbase;
    logic [SLAVES-1:0][31:0]  smask;
    logic [SLAVES-1:0][31:0]  shrdata;
    logic [SLAVES-1:0]        shready;
    logic [SLAVES-1:0]        shresp;
    logic [SLAVES-1:0]        hsel;
    logic                     readyin;
    logic [31:0]              rdata;
    logic                     ready;
    logic                     resp;
    logic [SLAVES-1:0]        fence;
    logic                     fault;

    int checks = 0;
    int errors = 0;

    ahb_interconnect_dfs #(
        .SLAVES  (SLAVES),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (8)
    ) dut (
        .s_clk_i       (clk),
        .s_reset_i     (rst),
        .s_mhaddr_i    (haddr),
        .s_mhtrans_i   (htrans),
        .s_sbase_i     (sbase),
        .s_smask_i     (smask),
        .s_shrdata_i   (shrdata),
        .s_shready_i   (shready),
        .s_shresp_i    (shresp),
        .s_hsel_o      (hsel),
        .s_shreadyin_o (readyin),
        .s_shrdata_o   (rdata),
        .s_shready_o   (ready),
        .s_shresp_o    (resp),
        .s_fence_o     (fence),
        .s_fault_o     (fault)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [3:0]  hsel;
        logic        ready;
        logic        resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rsp(input string nm, input logic r, input logic e, input logic [31:0] d);
        chk({nm, " ready"}, {31'b0, ready}, {31'b0, r});
        chk({nm, " readyin"}, {31'b0, readyin}, {31'b0, r});
        chk({nm, " resp"}, {31'b0, resp}, {31'b0, e});
        chk({nm, " rdata"}, rdata, d);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [31:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        shready = '1;
        shresp  = '0;
    endtask

    initial begin
        sbase   = '{32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
        smask   = '{32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
        shrdata = '{32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_A0A0};
        shready = '1;
        shresp  = '0;
        haddr   = 32'h1000_0000;
        htrans  = IDLE;
        rst     = 1'b1;

        vecs[0] = '{32'h1000_0040, NONSEQ, 4'b0010, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h0000_0100, NONSEQ, 4'b0001, 1'b1, 1'b0, 32'hA0A0_A0A0};
        vecs[2] = '{32'h2000_0000, NONSEQ, 4'b0100, 1'b1, 1'b0, 32'h2222_2222};
        vecs[3] = '{32'h3000_0010, SEQ,    4'b1000, 1'b1, 1'b0, 32'h3333_3333};
        vecs[4] = '{32'h1000_0000, IDLE,   4'b0010, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'hF000_0000, IDLE,   4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'hF000_0000, BUSY,   4'b0000, 1'b1, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h2FFF_FFFC, NONSEQ, 4'b0100, 1'b1, 1'b0, 32'h2222_2222};
        vecs[8] = '{32'h3FFF_0000, NONSEQ, 4'b1000, 1'b1, 1'b0, 32'h3333_3333};

        // Reset state: idle response, hsel still follows the address.
        #3;
        chk_rsp("reset", 1'b1, 1'b0, 32'h0);
        chk("reset hsel", {28'b0, hsel}, 32'h2);
        chk("reset fence", {28'b0, fence}, 32'h0);
        chk("reset fault", {31'b0, fault}, 32'h0);
        cyc();
        rst = 1'b0;

        for (int v = 0; v < 9; v++) begin
            drv(vecs[v].addr, vecs[v].trans);
            chk($sformatf("vec%0d hsel", v), {28'b0, hsel}, {28'b0, vecs[v].hsel});
            cyc();
            drv(32'hF000_0000, IDLE);
            chk_rsp($sformatf("vec%0d", v), vecs[v].ready, vecs[v].resp, vecs[v].rdata);
        end

        // Slave stall and error response pass straight through.
        drv(32'h1000_0000, NONSEQ);
        shready[1] = 1'b0;
        cyc();
        drv(32'hF000_0000, IDLE);
        chk_rsp("stall1", 1'b0, 1'b0, 32'hDEAD_BEEF);
        cyc();
        chk_rsp("stall2", 1'b0, 1'b0, 32'hDEAD_BEEF);
        shready[1] = 1'b1;
        shresp[1]  = 1'b1;
        #1;
        chk_rsp("stall end", 1'b1, 1'b1, 32'hDEAD_BEEF);
        cyc();
        shresp[1] = 1'b0;
        chk_rsp("after stall", 1'b1, 1'b0, 32'h0);

        // Unmapped NONSEQ held: ERR1, ERR2, ERR1, ERR2, then OKAY.
        drv(32'hF000_0000, NONSEQ);
        chk("unmapped hsel", {28'b0, hsel}, 32'h0);
        cyc();
        chk_rsp("err1 a", 1'b0, 1'b1, 32'h0);
        cyc();
        chk_rsp("err2 a", 1'b1, 1'b1, 32'h0);
        cyc();
        chk_rsp("err1 b", 1'b0, 1'b1, 32'h0);
        drv(32'hF000_0000, IDLE);
        cyc();
        chk_rsp("err2 b", 1'b1, 1'b1, 32'h0);
        cyc();
        chk_rsp("err done", 1'b1, 1'b0, 32'h0);

        // Reset during a slave stall.
        drv(32'h1000_0000, NONSEQ);
        shready[1] = 1'b0;
        cyc();
        drv(32'hF000_0000, IDLE);
        chk_rsp("pre-reset stall", 1'b0, 1'b0, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        chk_rsp("reset in stall", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        shready[1] = 1'b1;

        // Reset during ERR1.
        cyc();
        drv(32'hF000_0000, NONSEQ);
        cyc();
        drv(32'hF000_0000, IDLE);
        chk_rsp("pre-reset err1", 1'b0, 1'b1, 32'h0);
        rst = 1'b1;
        #1;
        chk_rsp("reset in err1", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        cyc();
        chk_rsp("post reset", 1'b1, 1'b0, 32'h0);

`ifdef AHB_IC_TIMEOUT_EN
        // Watchdog expiry after 8 stalled cycles fences slave 1.
        drv(32'h1000_0000, NONSEQ);
        shready[1] = 1'b0;
        cyc();
        drv(32'hF000_0000, IDLE);
        for (int k = 0; k < 7; k++) cyc();
        chk_rsp("wd cycle8", 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("wd fault early", {31'b0, fault}, 32'h0);
        cyc();
        chk_rsp("wd err1", 1'b0, 1'b1, 32'h0);
        chk("wd fence", {28'b0, fence}, 32'h2);
        chk("wd fault", {31'b0, fault}, 32'h1);
        shready[1] = 1'b1;
        cyc();
        chk_rsp("wd err2", 1'b1, 1'b1, 32'h0);
        cyc();
        chk_rsp("wd idle", 1'b1, 1'b0, 32'h0);
        drv(32'h1000_0000, NONSEQ);
        chk("fenced hsel", {28'b0, hsel}, 32'h0);
        cyc();
        drv(32'hF000_0000, IDLE);
        chk_rsp("fenced err1", 1'b0, 1'b1, 32'h0);
        cyc();
        chk_rsp("fenced err2", 1'b1, 1'b1, 32'h0);
        chk("fault sticky", {31'b0, fault}, 32'h1);

        // Slave ready on the expiry cycle wins.
        do_reset();
        chk("reset clears fence", {28'b0, fence}, 32'h0);
        drv(32'h1000_0000, NONSEQ);
        chk("unfenced hsel", {28'b0, hsel}, 32'h2);
        shready[1] = 1'b0;
        cyc();
        drv(32'hF000_0000, IDLE);
        for (int k = 0; k < 7; k++) cyc();
        shready[1] = 1'b1;
        #1;
        chk_rsp("wd late ready", 1'b1, 1'b0, 32'hDEAD_BEEF);
        cyc();
        chk_rsp("wd no err", 1'b1, 1'b0, 32'h0);
        chk("wd no fault", {31'b0, fault}, 32'h0);
        chk("wd no fence", {28'b0, fence}, 32'h0);
`else
        // Without the watchdog a long stall just waits.
        drv(32'h1000_0000, NONSEQ);
        shready[1] = 1'b0;
        cyc();
        drv(32'hF000_0000, IDLE);
        for (int k = 0; k < 20; k++) cyc();
        chk_rsp("long stall", 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("no fence", {28'b0, fence}, 32'h0);
        chk("no fault", {31'b0, fault}, 32'h0);
        shready[1] = 1'b1;
        cyc();
        chk_rsp("long stall end", 1'b1, 1'b0, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
